// File: rtl/sram_req_queue.sv
// sram_req_queue
//   Request front-end for the 23K640 SPI SRAM controller. Application
//   read/write requests are buffered in a small FIFO and issued one at a
//   time. The FIFO head drives the controller address/data/direction, so
//   those stay stable for the whole serial transaction. Completion is taken
//   from the controller's busy (inverted chip-select). Read data comes back
//   on a valid/ready response channel.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-low reset
//   i_req_*/o_req_ready request channel (push when valid & ready)
//   o_rsp_*/i_rsp_ready read response channel
//   o_en, o_rd_n_wr,
//   o_addr, o_data      controller command (head of FIFO)
//   i_busy, i_rdata     controller status and read data
//   o_level             FIFO occupancy
module sram_req_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic                     i_req_rd_n_wr,
  input  logic [AW-1:0]            i_req_addr,
  input  logic [DW-1:0]            i_req_data,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [DW-1:0]            o_rsp_data,
  output logic                     o_en,
  output logic                     o_rd_n_wr,
  output logic [AW-1:0]            o_addr,
  output logic [DW-1:0]            o_data,
  input  logic                     i_busy,
  input  logic [DW-1:0]            i_rdata,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef struct packed {
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   level;
  logic          push;
  logic          pop;
  logic          capture;
  state_t        state;
  state_t        state_nxt;

  assign head        = mem[rd_ptr];
  assign o_req_ready = (level != FULL);
  assign push        = i_req_valid && o_req_ready;
  assign pop         = (state == DONE);
  assign o_level     = level;
  assign o_rd_n_wr   = head.rd;
  assign o_addr      = head.addr;
  assign o_data      = head.data;

  // Read data is valid on the cycle the controller drops busy.
  assign capture     = (state == BUSY) && !i_busy && head.rd;

  // FIFO storage and pointers. Storage is cleared so the head reads as
  // zero after reset. Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{rd: i_req_rd_n_wr, addr: i_req_addr, data: i_req_data};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + (PW+1)'(1);
        2'b01:   level <= level - (PW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // A read is held in IDLE while an unconsumed response is pending, so a
  // new capture never collides with a consume.
  always_comb begin
    state_nxt = state;
    o_en      = 1'b0;
    case (state)
      IDLE: begin
        if (level != '0 && (!head.rd || !o_rsp_valid)) state_nxt = ISSUE;
      end
      ISSUE: begin
        o_en = 1'b1;
        if (i_busy) state_nxt = BUSY;
      end
      BUSY: begin
        if (!i_busy) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
    end else if (capture) begin
      o_rsp_valid <= 1'b1;
      o_rsp_data  <= i_rdata;
    end else if (o_rsp_valid && i_rsp_ready) begin
      o_rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sram_req_queue.sv
module tb_sram_req_queue;

  logic        clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_rd_n_wr = 1'b0;
  logic [15:0] i_req_addr = '0;
  logic [7:0]  i_req_data = '0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b0;
  logic [7:0]  o_rsp_data;
  logic        o_en;
  logic        o_rd_n_wr;
  logic [15:0] o_addr;
  logic [7:0]  o_data;
  logic        i_busy = 1'b0;
  logic [7:0]  i_rdata = '0;
  logic [2:0]  o_level;

  int checks = 0;
  int errors = 0;

  // Controller model state (used in the wrap test)
  logic        auto_ctrl = 1'b0;
  logic        mon_en = 1'b0;
  logic [7:0]  sram [256];
  logic [7:0]  expq [$];
  int          got_n = 0;

  always #5 clk = ~clk;

  sram_req_queue #(.DEPTH(4), .AW(16), .DW(8)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_rd_n_wr(i_req_rd_n_wr), .i_req_addr(i_req_addr),
    .i_req_data(i_req_data),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_data(o_rsp_data),
    .o_en(o_en), .o_rd_n_wr(o_rd_n_wr), .o_addr(o_addr), .o_data(o_data),
    .i_busy(i_busy), .i_rdata(i_rdata), .o_level(o_level)
  );

  typedef struct {
    logic        rst;
    logic        vld;
    logic        rd;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        busy;
    logic [7:0]  rdata;
    logic        rsp_rdy;
    logic        x_en;
    logic [2:0]  x_lvl;
    logic        x_rdy;
    logic        x_rv;
    logic [7:0]  x_rsp;
    logic [15:0] x_addr;
    logic [7:0]  x_data;
    logic        x_rd;
  } vec_t;

  vec_t tbl [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic rd, input logic [15:0] a, input logic [7:0] d);
    int n = 0;
    i_req_valid = 1'b1; i_req_rd_n_wr = rd; i_req_addr = a; i_req_data = d;
    while (!o_req_ready && n < 50) begin tick(); n++; end
    chk("push_ready_wait", 32'(n < 50), 32'd1);
    tick();
    i_req_valid = 1'b0;
  endtask

  // Manually play one controller transaction for the head entry.
  task automatic serve(input logic [15:0] exp_addr, input logic [7:0] rd_val);
    int n = 0;
    while (!o_en && n < 20) begin tick(); n++; end
    chk("serve_en", 32'(o_en), 32'd1);
    chk("serve_addr", 32'(o_addr), 32'(exp_addr));
    i_busy = 1'b1;
    tick();
    chk("serve_en_drop", 32'(o_en), 32'd0);
    tick();
    i_rdata = rd_val;
    i_busy  = 1'b0;
    tick();
    i_rdata = 8'h00;
    tick();
  endtask

  // Behavioural controller: accepts o_en, runs busy for a few cycles,
  // performs the access against a byte array.
  initial begin
    logic [15:0] ca;
    logic [7:0]  cd;
    logic        cr;
    forever begin
      @(posedge clk); #2;
      if (auto_ctrl && o_en) begin
        ca = o_addr; cd = o_data; cr = o_rd_n_wr;
        i_busy = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        if (cr) i_rdata = sram[ca[7:0]];
        else    sram[ca[7:0]] = cd;
        i_busy = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (mon_en && o_rsp_valid && i_rsp_ready) begin
        if (expq.size() == 0) chk("wrap_extra_rsp", 32'(o_rsp_data), 32'hFFFF);
        else chk("wrap_rdata", 32'(o_rsp_data), 32'(expq.pop_front()));
        got_n++;
      end
    end
  end

  initial begin
    //          rst   vld   rd    addr      data   busy  rdata  rsprdy | en    lvl   rdy   rv    rsp    addr      data   rd
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0,  1'b0, 3'd0, 1'b1, 1'b0, 8'h00, 16'h0000, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0,  1'b0, 3'd0, 1'b1, 1'b0, 8'h00, 16'h0000, 8'h00, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 16'h1234, 8'h5A, 1'b0, 8'h00, 1'b0,  1'b0, 3'd1, 1'b1, 1'b0, 8'h00, 16'h1234, 8'h5A, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0,  1'b1, 3'd1, 1'b1, 1'b0, 8'h00, 16'h1234, 8'h5A, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'h00, 1'b0,  1'b0, 3'd1, 1'b1, 1'b0, 8'h00, 16'h1234, 8'h5A, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'h00, 1'b0,  1'b0, 3'd1, 1'b1, 1'b0, 8'h00, 16'h1234, 8'h5A, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0,  1'b0, 3'd1, 1'b1, 1'b0, 8'h00, 16'h1234, 8'h5A, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0,  1'b0, 3'd0, 1'b1, 1'b0, 8'h00, 16'h0000, 8'h00, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 16'h00FF, 8'h00, 1'b0, 8'h00, 1'b0,  1'b0, 3'd1, 1'b1, 1'b0, 8'h00, 16'h00FF, 8'h00, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0,  1'b1, 3'd1, 1'b1, 1'b0, 8'h00, 16'h00FF, 8'h00, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'h00, 1'b0,  1'b0, 3'd1, 1'b1, 1'b0, 8'h00, 16'h00FF, 8'h00, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'hA5, 1'b0,  1'b0, 3'd1, 1'b1, 1'b1, 8'hA5, 16'h00FF, 8'h00, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0,  1'b0, 3'd0, 1'b1, 1'b1, 8'hA5, 16'h0000, 8'h00, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b1,  1'b0, 3'd0, 1'b1, 1'b0, 8'hA5, 16'h0000, 8'h00, 1'b0};

    // Reset state, single write, single read
    for (int i = 0; i < 14; i++) begin
      i_rst = tbl[i].rst; i_req_valid = tbl[i].vld; i_req_rd_n_wr = tbl[i].rd;
      i_req_addr = tbl[i].addr; i_req_data = tbl[i].data; i_busy = tbl[i].busy;
      i_rdata = tbl[i].rdata; i_rsp_ready = tbl[i].rsp_rdy;
      tick();
      chk($sformatf("v%0d_en", i),    32'(o_en),        32'(tbl[i].x_en));
      chk($sformatf("v%0d_level", i), 32'(o_level),     32'(tbl[i].x_lvl));
      chk($sformatf("v%0d_ready", i), 32'(o_req_ready), 32'(tbl[i].x_rdy));
      chk($sformatf("v%0d_rspv", i),  32'(o_rsp_valid), 32'(tbl[i].x_rv));
      chk($sformatf("v%0d_rspd", i),  32'(o_rsp_data),  32'(tbl[i].x_rsp));
      chk($sformatf("v%0d_addr", i),  32'(o_addr),      32'(tbl[i].x_addr));
      chk($sformatf("v%0d_data", i),  32'(o_data),      32'(tbl[i].x_data));
      chk($sformatf("v%0d_rdnwr", i), 32'(o_rd_n_wr),   32'(tbl[i].x_rd));
    end
    i_req_valid = 1'b0; i_rsp_ready = 1'b0; i_busy = 1'b0; i_rdata = 8'h00;

    // Full FIFO, refused push, push during DONE, ordering
    i_req_valid = 1'b1; i_req_rd_n_wr = 1'b0; i_req_addr = 16'd0; i_req_data = 8'h10;
    tick(); chk("full_lvl1", 32'(o_level), 32'd1);
    i_req_addr = 16'd1; i_req_data = 8'h11;
    tick(); chk("full_lvl2", 32'(o_level), 32'd2);
    chk("full_en", 32'(o_en), 32'd1);
    chk("full_addr0", 32'(o_addr), 32'd0);
    i_busy = 1'b1; i_req_addr = 16'd2; i_req_data = 8'h12;
    tick(); chk("full_lvl3", 32'(o_level), 32'd3);
    i_req_addr = 16'd3; i_req_data = 8'h13;
    tick(); chk("full_lvl4", 32'(o_level), 32'd4);
    chk("full_ready0", 32'(o_req_ready), 32'd0);
    i_req_addr = 16'd4; i_req_data = 8'h14;
    tick(); chk("full_refused", 32'(o_level), 32'd4);
    i_busy = 1'b0;
    tick(); chk("full_done_lvl", 32'(o_level), 32'd4);
    i_req_valid = 1'b0;
    tick(); chk("full_pop_lvl", 32'(o_level), 32'd3);
    chk("full_ready1", 32'(o_req_ready), 32'd1);
    tick(); chk("full_addr1", 32'(o_addr), 32'd1);
    chk("full_en1", 32'(o_en), 32'd1);
    i_busy = 1'b1; tick();
    i_busy = 1'b0; tick(); chk("done_lvl3", 32'(o_level), 32'd3);
    i_req_valid = 1'b1; i_req_addr = 16'd4; i_req_data = 8'h14;
    tick(); chk("push_in_done", 32'(o_level), 32'd3);
    i_req_valid = 1'b0;
    serve(16'd2, 8'h00);
    serve(16'd3, 8'h00);
    chk("full_data4", 32'(o_data), 32'h14);
    serve(16'd4, 8'h00);
    chk("full_empty", 32'(o_level), 32'd0);

    // Response backpressure blocks later reads; write waits in order
    i_rsp_ready = 1'b0;
    push(1'b1, 16'h0010, 8'h00);
    push(1'b1, 16'h0020, 8'h00);
    push(1'b0, 16'h0030, 8'hC3);
    serve(16'h0010, 8'h77);
    chk("bp_rspv", 32'(o_rsp_valid), 32'd1);
    chk("bp_rspd", 32'(o_rsp_data), 32'h77);
    for (int i = 0; i < 5; i++) begin
      tick(); chk($sformatf("bp_blocked%0d", i), 32'(o_en), 32'd0);
    end
    chk("bp_lvl", 32'(o_level), 32'd2);
    i_rsp_ready = 1'b1; tick(); i_rsp_ready = 1'b0;
    chk("bp_consumed", 32'(o_rsp_valid), 32'd0);
    serve(16'h0020, 8'h88);
    chk("bp_rspd2", 32'(o_rsp_data), 32'h88);
    serve(16'h0030, 8'h00);
    chk("bp_wr_norsp", 32'(o_rsp_valid), 32'd1);
    chk("bp_wr_rspd", 32'(o_rsp_data), 32'h88);
    chk("bp_empty", 32'(o_level), 32'd0);

    // Reset while BUSY, then stale busy in IDLE
    push(1'b0, 16'h0060, 8'hC0);
    push(1'b0, 16'h0061, 8'hC1);
    chk("rb_issue", 32'(o_en), 32'd1);
    i_busy = 1'b1; tick();
    chk("rb_lvl2", 32'(o_level), 32'd2);
    i_rst = 1'b0; tick(); i_rst = 1'b1;
    chk("rb_en", 32'(o_en), 32'd0);
    chk("rb_lvl", 32'(o_level), 32'd0);
    chk("rb_rspv", 32'(o_rsp_valid), 32'd0);
    chk("rb_rspd", 32'(o_rsp_data), 32'd0);
    chk("rb_ready", 32'(o_req_ready), 32'd1);
    chk("rb_addr", 32'(o_addr), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(); chk($sformatf("stale_busy%0d", i), 32'(o_en), 32'd0);
    end
    i_busy = 1'b0;
    push(1'b0, 16'h0070, 8'hC7);
    serve(16'h0070, 8'h00);
    chk("rb_after_empty", 32'(o_level), 32'd0);

    // Wrap: 10 alternating writes/reads through the controller model
    auto_ctrl = 1'b1; mon_en = 1'b1; i_rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      logic [7:0] d;
      d = 8'(8'h30 + 7 * i);
      expq.push_back(d);
      push(1'b0, 16'(16'h0100 + i), d);
      push(1'b1, 16'(16'h0100 + i), 8'h00);
    end
    begin
      int n = 0;
      while ((got_n < 5 || o_level != 3'd0) && n < 400) begin tick(); n++; end
      chk("wrap_timeout", 32'(n < 400), 32'd1);
    end
    repeat (3) tick();
    chk("wrap_count", 32'(got_n), 32'd5);
    chk("wrap_lvl", 32'(o_level), 32'd0);
    mon_en = 1'b0; auto_ctrl = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
